// File: rtl/mult_hilo_unit.sv
// HI/LO register unit: sequences an external multiplier and writes HI/LO from mult/mthi/mtlo.
// Optional `MULT_TIMEOUT_EN adds a sticky err output and a bounded WAIT state.
module mult_hilo_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  input  logic               op_mult,
  input  logic               op_mthi,
  input  logic               op_mtlo,
  input  logic               op_signed,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               rd_req,
  output logic               op_ready,
  output logic               stall,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
`ifdef MULT_TIMEOUT_EN
  output logic               err,
`endif
  output logic               mult_start,
  output logic               mult_signed,
  output logic [WIDTH-1:0]   mult_src_a,
  output logic [WIDTH-1:0]   mult_src_b,
  input  logic               mult_ready,
  input  logic               mult_done,
  input  logic [2*WIDTH-1:0] mult_product
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hold_a_q, hold_a_d;
  logic [WIDTH-1:0] hold_b_q, hold_b_d;
  logic             hold_signed_q, hold_signed_d;

  logic accept;
  logic do_mult;
  logic do_mthi;
  logic do_mtlo;
  logic capture;
  logic timeout;

  assign accept  = op_valid & op_ready;
  assign do_mult = accept & op_mult;
  assign do_mthi = accept & ~op_mult & op_mthi;
  assign do_mtlo = accept & ~op_mult & ~op_mthi & op_mtlo;
  // Done is only honoured in WAIT so a level-high done left over from the last op is ignored.
  assign capture = (state_q == StWait) & mult_done;

`ifdef MULT_TIMEOUT_EN
  localparam int unsigned TimeoutCycles = 2 * WIDTH + 4;
  localparam int unsigned CntW          = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            err_q, err_d;

  assign timeout = (state_q == StWait) & ~mult_done &
                   (wait_cnt_q == CntW'(TimeoutCycles - 1));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == StIssue) begin
      wait_cnt_d = '0;
    end else if (state_q == StWait) begin
      wait_cnt_d = wait_cnt_q + CntW'(1);
    end
    err_d = err_q | timeout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (do_mult) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (mult_done || timeout) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy       = (state_q != StIdle);
    op_ready   = (state_q == StIdle) & mult_ready;
    mult_start = (state_q == StIssue);
    stall      = (op_valid & ~op_ready) | (rd_req & busy);
  end

  // HI/LO and operand holding registers
  always_comb begin
    hi_d          = hi_q;
    lo_d          = lo_q;
    hold_a_d      = hold_a_q;
    hold_b_d      = hold_b_q;
    hold_signed_d = hold_signed_q;
    if (do_mult) begin
      hold_a_d      = op_a;
      hold_b_d      = op_b;
      hold_signed_d = op_signed;
    end
    if (do_mthi) hi_d = op_a;
    if (do_mtlo) lo_d = op_a;
    if (capture) begin
      hi_d = mult_product[2*WIDTH-1:WIDTH];
      lo_d = mult_product[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q          <= '0;
      lo_q          <= '0;
      hold_a_q      <= '0;
      hold_b_q      <= '0;
      hold_signed_q <= 1'b0;
    end else begin
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      hold_a_q      <= hold_a_d;
      hold_b_q      <= hold_b_d;
      hold_signed_q <= hold_signed_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign mult_src_a  = hold_a_q;
  assign mult_src_b  = hold_b_q;
  assign mult_signed = hold_signed_q;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit at WIDTH=4 with a small behavioural multiplier attached.
// Timeout checks are compiled in when MULT_TIMEOUT_EN is defined.
module tb_mult_hilo_unit;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           op_valid, op_mult, op_mthi, op_mtlo, op_signed;
  logic [W-1:0]   op_a, op_b;
  logic           rd_req;
  logic           op_ready, stall, busy;
  logic [W-1:0]   hi, lo;
  logic           mult_start, mult_signed;
  logic [W-1:0]   mult_src_a, mult_src_b;
  logic           mult_ready, mult_done;
  logic [2*W-1:0] mult_product;
`ifdef MULT_TIMEOUT_EN
  logic           err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  mult_hilo_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_mult      (op_mult),
    .op_mthi      (op_mthi),
    .op_mtlo      (op_mtlo),
    .op_signed    (op_signed),
    .op_a         (op_a),
    .op_b         (op_b),
    .rd_req       (rd_req),
    .op_ready     (op_ready),
    .stall        (stall),
    .hi           (hi),
    .lo           (lo),
    .busy         (busy),
`ifdef MULT_TIMEOUT_EN
    .err          (err),
`endif
    .mult_start   (mult_start),
    .mult_signed  (mult_signed),
    .mult_src_a   (mult_src_a),
    .mult_src_b   (mult_src_b),
    .mult_ready   (mult_ready),
    .mult_done    (mult_done),
    .mult_product (mult_product)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: zero operands finish at the start edge, others after b cycles.
  // done stays high until the next start.
  logic         m_run, m_done, m_ready_en, stub_hold;
  logic [W-1:0] m_cnt;
  logic [2*W-1:0] m_prod;

  assign mult_ready   = m_ready_en & ~m_run;
  assign mult_done    = m_done & ~stub_hold;
  assign mult_product = m_prod;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= '0;
      m_prod <= '0;
    end else if (mult_start) begin
      if (mult_src_a == '0 || mult_src_b == '0) begin
        m_prod <= '0;
        m_done <= 1'b1;
        m_run  <= 1'b0;
      end else begin
        m_prod <= mult_signed ? ({{W{mult_src_a[W-1]}}, mult_src_a} *
                                 {{W{mult_src_b[W-1]}}, mult_src_b})
                              : ({{W{1'b0}}, mult_src_a} * {{W{1'b0}}, mult_src_b});
        m_done <= 1'b0;
        m_run  <= 1'b1;
        m_cnt  <= mult_src_b;
      end
    end else if (m_run) begin
      if (m_cnt == '0) begin
        m_run  <= 1'b0;
        m_done <= 1'b1;
      end else begin
        m_cnt <= m_cnt - 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    op_valid  = 1'b0;
    op_mult   = 1'b0;
    op_mthi   = 1'b0;
    op_mtlo   = 1'b0;
    op_signed = 1'b0;
    op_a      = '0;
    op_b      = '0;
  endtask

  task automatic drive_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    op_valid  = 1'b1;
    op_mult   = 1'b1;
    op_mthi   = 1'b0;
    op_mtlo   = 1'b0;
    op_signed = s;
    op_a      = a;
    op_b      = b;
  endtask

  // Bounded wait for the multiply to finish; an expired bound shows up as busy still high.
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    rd_req     = 1'b0;
    m_ready_en = 1'b1;
    stub_hold  = 1'b0;
    idle_inputs();
    tick();
    tick();

    // Reset state
    chk("rst_hi",    {28'b0, hi}, 32'h0);
    chk("rst_lo",    {28'b0, lo}, 32'h0);
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_start", {31'b0, mult_start}, 32'd0);
`ifdef MULT_TIMEOUT_EN
    chk("rst_err",   {31'b0, err}, 32'd0);
`endif
    reset = 1'b0;
    tick();
    chk("ready_follows_1", {31'b0, op_ready}, 32'd1);
    m_ready_en = 1'b0;
    op_valid   = 1'b1;
    #1;
    chk("ready_follows_0", {31'b0, op_ready}, 32'd0);
    chk("stall_not_ready", {31'b0, stall}, 32'd1);
    m_ready_en = 1'b1;
    op_valid   = 1'b0;
    #1;

    // 3 * 5 signed -> 0x0F
    drive_mult(4'd3, 4'd5, 1'b1);
    #1;
    chk("m1_accept_ready", {31'b0, op_ready}, 32'd1);
    chk("m1_accept_stall", {31'b0, stall}, 32'd0);
    tick();
    idle_inputs();
    chk("m1_issue_start", {31'b0, mult_start}, 32'd1);
    chk("m1_src_a",       {28'b0, mult_src_a}, 32'h3);
    chk("m1_src_b",       {28'b0, mult_src_b}, 32'h5);
    chk("m1_signed",      {31'b0, mult_signed}, 32'd1);
    tick();
    chk("m1_wait_start",  {31'b0, mult_start}, 32'd0);
    wait_idle("m1_done");
    chk("m1_hi", {28'b0, hi}, 32'h0);
    chk("m1_lo", {28'b0, lo}, 32'hF);

    // 0 * 7 with a stale done still high: must capture on the 3rd edge, not earlier
    drive_mult(4'd0, 4'd7, 1'b0);
    tick();
    idle_inputs();
    chk("m0_e1_busy",  {31'b0, busy}, 32'd1);
    chk("m0_e1_start", {31'b0, mult_start}, 32'd1);
    tick();
    chk("m0_e2_busy",  {31'b0, busy}, 32'd1);
    chk("m0_e2_lo",    {28'b0, lo}, 32'hF);
    tick();
    chk("m0_e3_busy",  {31'b0, busy}, 32'd0);
    chk("m0_e3_hi",    {28'b0, hi}, 32'h0);
    chk("m0_e3_lo",    {28'b0, lo}, 32'h0);

    // -2 * 3 signed -> 0xFA, with rd_req held and an mthi waiting behind it
    rd_req = 1'b1;
    #1;
    chk("rd_idle_stall", {31'b0, stall}, 32'd0);
    drive_mult(4'hE, 4'd3, 1'b1);
    tick();
    op_mult = 1'b0;
    op_mthi = 1'b1;
    op_a    = 4'd6;
    #1;
    for (int i = 0; i < 40 && busy === 1'b1; i++) begin
      chk("m2_busy_stall",    {31'b0, stall}, 32'd1);
      chk("m2_busy_ready",    {31'b0, op_ready}, 32'd0);
      chk("m2_busy_hi_held",  {28'b0, hi}, 32'h0);
      tick();
    end
    chk("m2_done",        {31'b0, busy}, 32'd0);
    chk("m2_after_stall", {31'b0, stall}, 32'd0);
    chk("m2_hi", {28'b0, hi}, 32'hF);
    chk("m2_lo", {28'b0, lo}, 32'hA);
    tick();
    chk("mthi_held_hi", {28'b0, hi}, 32'h6);
    chk("mthi_held_lo", {28'b0, lo}, 32'hA);
    idle_inputs();
    rd_req = 1'b0;

    // mthi has priority over mtlo
    op_valid = 1'b1;
    op_mthi  = 1'b1;
    op_mtlo  = 1'b1;
    op_a     = 4'd9;
    tick();
    chk("mthi_pri_hi", {28'b0, hi}, 32'h9);
    chk("mthi_pri_lo", {28'b0, lo}, 32'hA);

    // valid with no select: accepted, no effect
    op_mthi = 1'b0;
    op_mtlo = 1'b0;
    op_a    = 4'd5;
    #1;
    chk("nosel_ready", {31'b0, op_ready}, 32'd1);
    tick();
    chk("nosel_hi",   {28'b0, hi}, 32'h9);
    chk("nosel_lo",   {28'b0, lo}, 32'hA);
    chk("nosel_busy", {31'b0, busy}, 32'd0);

    // mtlo alone
    op_mtlo = 1'b1;
    op_a    = 4'hC;
    tick();
    chk("mtlo_lo", {28'b0, lo}, 32'hC);
    chk("mtlo_hi", {28'b0, hi}, 32'h9);

    // reset asserted in WAIT aborts the multiply
    drive_mult(4'd7, 4'd7, 1'b0);
    tick();
    idle_inputs();
    tick();
    chk("rw_in_wait", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rw_hi",    {28'b0, hi}, 32'h0);
    chk("rw_lo",    {28'b0, lo}, 32'h0);
    chk("rw_busy",  {31'b0, busy}, 32'd0);
    chk("rw_src_a", {28'b0, mult_src_a}, 32'h0);
    reset = 1'b0;
    tick();
    chk("rw_idle_next",  {31'b0, busy}, 32'd0);
    chk("rw_ready_next", {31'b0, op_ready}, 32'd1);

`ifdef MULT_TIMEOUT_EN
    // Timeout: done held low, err after 12 WAIT cycles, hi/lo untouched
    op_valid = 1'b1;
    op_mthi  = 1'b1;
    op_a     = 4'd3;
    tick();
    op_mthi  = 1'b0;
    op_mtlo  = 1'b1;
    op_a     = 4'h5;
    tick();
    idle_inputs();
    stub_hold = 1'b1;
    drive_mult(4'd1, 4'd1, 1'b0);
    tick();
    idle_inputs();
    tick();
    for (int i = 0; i < 11; i++) begin
      tick();
      chk("to_pending_busy", {31'b0, busy}, 32'd1);
      chk("to_pending_err",  {31'b0, err}, 32'd0);
    end
    tick();
    chk("to_err",  {31'b0, err}, 32'd1);
    chk("to_busy", {31'b0, busy}, 32'd0);
    chk("to_hi",   {28'b0, hi}, 32'h3);
    chk("to_lo",   {28'b0, lo}, 32'h5);
    tick();
    chk("to_err_sticky", {31'b0, err}, 32'd1);
    stub_hold = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
